// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, reads the combinational ROM, and
// buffers {pc, instr} pairs in a small FIFO feeding decode over valid/ready.
module ifetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [31:0]   pc;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   mem_pc    [DEPTH];
   logic [31:0]   mem_instr [DEPTH];
   logic          pop;
   logic          push;

   assign imem_addr = pc;

   // Outputs are gated by rst so the bus reads idle for the whole reset cycle.
   assign out_valid = !rst && (count != '0);
   assign pop       = out_valid && out_ready;
   assign push      = !rst && !redirect_valid && !halt && ((count < FULL) || pop);
   assign busy      = !rst && (out_valid || !halt);

   always_comb begin
      out_pc    = '0;
      out_instr = '0;
      if (out_valid) begin
         out_pc    = mem_pc[rd_ptr];
         out_instr = mem_instr[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr]    <= pc;
         mem_instr[wr_ptr] <= imem_instr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC & 32'hFFFF_FFFC;
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (redirect_valid) begin
         pc     <= redirect_pc & 32'hFFFF_FFFC;
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) begin
            pc     <= pc + 32'd4;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed vector table, a back-to-back redirect
// sequence, then random traffic against a queue-based reference model.
module tb_ifetch_ctrl;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        busy;

   logic [31:0] rom [256];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign imem_instr = rom[imem_addr[9:2]];

   ifetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_instr(out_instr), .busy(busy)
   );

   typedef struct {
      logic        rst, rv;
      logic [31:0] rpc;
      logic        halt, rdy;
      logic        ev, eb;
      logic [31:0] epc, eaddr;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   vec_t tbl[$];
   ent_t mq[$];
   logic [31:0] mpc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic addv(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic h, input logic rdy, input logic ev,
                       input logic eb, input logic [31:0] epc, input logic [31:0] ea);
      vec_t v;
      v.rst = r; v.rv = rv; v.rpc = rpc; v.halt = h; v.rdy = rdy;
      v.ev = ev; v.eb = eb; v.epc = epc; v.eaddr = ea;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic r, input logic rv, input logic [31:0] rpc,
                        input logic h, input logic rdy);
      rst = r; redirect_valid = rv; redirect_pc = rpc; halt = h; out_ready = rdy;
   endtask

   // Called mid-cycle, after inputs settle and well before the next edge.
   task automatic chk_out(input string tag, input logic ev, input logic eb,
                          input logic [31:0] epc, input logic [31:0] ea);
      logic [31:0] eidx;
      eidx = {24'd0, epc[9:2]};
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
      chk({tag, ".busy"},  {31'd0, busy},      {31'd0, eb});
      chk({tag, ".addr"},  imem_addr, ea);
      if (ev) begin
         chk({tag, ".pc"},    out_pc, epc);
         chk({tag, ".instr"}, out_instr, rom[eidx]);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         rom[i] = {8'(i), 8'hC3, 8'(255 - i), 8'h13};
      rom[0] = 32'h0010_0093;
      rom[1] = 32'h0030_0113;
      rom[2] = 32'h0020_81b3;

      //   rst rv rpc            halt rdy  ev eb epc            addr
      addv(1, 0, 32'h0,          0,   1,   0, 0, 32'h0,          32'h0);
      addv(1, 0, 32'h0,          0,   1,   0, 0, 32'h0,          32'h0);
      addv(0, 0, 32'h0,          0,   1,   0, 1, 32'h0,          32'h0);
      addv(0, 0, 32'h0,          0,   1,   1, 1, 32'h0,          32'h4);
      addv(0, 0, 32'h0,          0,   1,   1, 1, 32'h4,          32'h8);
      addv(0, 0, 32'h0,          0,   0,   1, 1, 32'h8,          32'hC);
      addv(0, 0, 32'h0,          0,   0,   1, 1, 32'h8,          32'h10);
      addv(0, 0, 32'h0,          0,   0,   1, 1, 32'h8,          32'h10);
      addv(0, 0, 32'h0,          0,   0,   1, 1, 32'h8,          32'h10);
      addv(0, 0, 32'h0,          0,   0,   1, 1, 32'h8,          32'h10);
      addv(0, 0, 32'h0,          0,   1,   1, 1, 32'h8,          32'h10);
      addv(0, 0, 32'h0,          0,   1,   1, 1, 32'hC,          32'h14);
      addv(0, 1, 32'h23,         0,   1,   1, 1, 32'h10,         32'h18);
      addv(0, 0, 32'h0,          0,   1,   0, 1, 32'h0,          32'h20);
      addv(0, 0, 32'h0,          0,   1,   1, 1, 32'h20,         32'h24);
      addv(0, 0, 32'h0,          1,   1,   1, 1, 32'h24,         32'h28);
      addv(0, 0, 32'h0,          1,   1,   0, 0, 32'h0,          32'h28);
      addv(0, 0, 32'h0,          1,   1,   0, 0, 32'h0,          32'h28);
      addv(0, 0, 32'h0,          1,   1,   0, 0, 32'h0,          32'h28);
      addv(0, 0, 32'h0,          0,   1,   0, 1, 32'h0,          32'h28);
      addv(0, 1, 32'hFFFF_FFFC,  0,   1,   1, 1, 32'h28,         32'h2C);
      addv(0, 0, 32'h0,          0,   1,   0, 1, 32'h0,          32'hFFFF_FFFC);
      addv(0, 0, 32'h0,          0,   1,   1, 1, 32'hFFFF_FFFC,  32'h0);
      addv(0, 0, 32'h0,          0,   0,   1, 1, 32'h0,          32'h4);
      addv(1, 1, 32'h40,         0,   0,   0, 0, 32'h0,          32'h8);
      addv(0, 0, 32'h0,          0,   1,   0, 1, 32'h0,          32'h0);
      addv(0, 0, 32'h0,          0,   1,   1, 1, 32'h0,          32'h4);
      addv(0, 0, 32'h0,          0,   1,   1, 1, 32'h4,          32'h8);
      addv(0, 0, 32'h0,          0,   1,   1, 1, 32'h8,          32'hC);

      #1;
      foreach (tbl[k]) begin
         drive(tbl[k].rst, tbl[k].rv, tbl[k].rpc, tbl[k].halt, tbl[k].rdy);
         #3;
         chk_out($sformatf("vec%0d", k), tbl[k].ev, tbl[k].eb, tbl[k].epc, tbl[k].eaddr);
         next_cycle();
      end

      // Back-to-back redirects: the last target wins, each suppresses its push.
      drive(0, 1, 32'h100, 0, 1);
      #3; next_cycle();
      drive(0, 1, 32'h202, 0, 1);
      #3; chk_out("b2b.a", 1'b0, 1'b1, 32'h0, 32'h100);
      next_cycle();
      drive(0, 0, 32'h0, 0, 1);
      #3; chk_out("b2b.b", 1'b0, 1'b1, 32'h0, 32'h200);
      next_cycle();
      #3; chk_out("b2b.c", 1'b1, 1'b1, 32'h200, 32'h204);
      next_cycle();

      // Random traffic against the reference model, starting from reset.
      drive(1, 0, 32'h0, 0, 1);
      #3;
      chk("rnd.rst.valid", {31'd0, out_valid}, 32'd0);
      chk("rnd.rst.busy",  {31'd0, busy}, 32'd0);
      next_cycle();
      mq.delete();
      mpc = RESET_PC & 32'hFFFF_FFFC;

      for (int c = 0; c < 3000; c++) begin
         logic r, rv, h, rdy, mv, mb, mpop, mpush;
         logic [31:0] rpc, hidx;
         ent_t e;
         r   = ($urandom_range(0, 99) < 2);
         rv  = ($urandom_range(0, 99) < 8);
         h   = ($urandom_range(0, 99) < 15);
         rdy = ($urandom_range(0, 99) < 65);
         rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                           : $urandom;
         drive(r, rv, rpc, h, rdy);
         #3;
         mv = !r && (mq.size() != 0);
         mb = !r && (mv || !h);
         chk("rnd.valid", {31'd0, out_valid}, {31'd0, mv});
         chk("rnd.busy",  {31'd0, busy}, {31'd0, mb});
         chk("rnd.addr",  imem_addr, mpc);
         if (mv) begin
            chk("rnd.pc",    out_pc, mq[0].pc);
            chk("rnd.instr", out_instr, mq[0].instr);
         end
         if (r) begin
            mq.delete();
            mpc = RESET_PC & 32'hFFFF_FFFC;
         end else begin
            mpop  = mv && rdy;
            mpush = !rv && !h && ((mq.size() < DEPTH) || mpop);
            if (mpop) void'(mq.pop_front());
            if (rv) begin
               mq.delete();
               mpc = rpc & 32'hFFFF_FFFC;
            end else if (mpush) begin
               hidx = {24'd0, mpc[9:2]};
               e.pc = mpc;
               e.instr = rom[hidx];
               mq.push_back(e);
               mpc = mpc + 32'd4;
            end
         end
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
